// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the arbitrated iterative multiplier.
// Holds the FSM state encoding, default width constants and the
// round-robin winner search used by mul_arb_ctrl.
package mul_arb_pkg;

   // Default operand width and the product/accumulator widths derived from it.
   // Each instance derives its own widths from its SZin parameter.
   localparam int unsigned SZIN_DEF = 8;
   localparam int unsigned PW       = 2 * SZIN_DEF - 1;
   localparam int unsigned ACCW     = 2 * SZIN_DEF;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Round-robin pick: search starts at ptr+1 and ascends with wrap-around, so
   // ptr itself has the lowest priority. Scanning from the far end toward ptr+1
   // lets the nearest set request overwrite the others. Supports up to 16
   // requesters; the caller guarantees req != 0 when the result is used.
   function automatic logic [3:0] rr_next(input logic [15:0] req,
                                          input logic [3:0]  ptr,
                                          input int          nreq);
      logic [3:0] win;
      int         idx;
      win = ptr;
      for (int k = 16; k >= 1; k--) begin
         if (k <= nreq) begin
            idx = int'(ptr) + k;
            if (idx >= nreq) idx = idx - nreq;
            if (req[idx[3:0]]) win = idx[3:0];
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/mul_seq_core.sv
// Iterative shift-add two's-complement multiplier.
// A start pulse captures both operands. SZ step cycles follow, consuming one
// bit of b per cycle, LSB first. The final step subtracts instead of adding
// because b's MSB carries negative weight. done/prod are valid combinationally
// during the last step cycle, so the caller can register them on that edge.
module mul_seq_core
   import mul_arb_pkg::*;
#(
   parameter int SZ = 8
)(
   input  logic            clk,
   input  logic            nres,
   input  logic            start,
   input  logic [SZ-1:0]   a,
   input  logic [SZ-1:0]   b,
   output logic            done,
   output logic [2*SZ-2:0] prod
);

   localparam int ACW = 2 * SZ;
   localparam int PWL = 2 * SZ - 1;
   localparam int CW  = (SZ > 1) ? $clog2(SZ) : 1;

   logic [SZ-1:0]         a_q;
   logic [SZ-1:0]         b_q;
   logic signed [ACW-1:0] acc_q;
   logic signed [ACW-1:0] acc_d;
   logic signed [ACW-1:0] a_ext;
   logic signed [ACW-1:0] a_shf;
   logic [CW-1:0]         cnt_q;
   logic                  run_q;
   logic                  is_msb;
   logic                  wrap;

   assign is_msb = (cnt_q == CW'(SZ - 1));
   assign done   = run_q && is_msb;

   // One partial-product step: add the shifted multiplicand for ordinary bits,
   // subtract it for the sign bit of b.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
      a_ext = {{SZ{a_q[SZ-1]}}, a_q};
      a_shf = a_ext << cnt_q;
      acc_d = acc_q;
      if (b_q[cnt_q]) begin
         acc_d = is_msb ? (acc_q - a_shf) : (acc_q + a_shf);
      end
   end

   // Only (-2^(SZ-1))^2 leaves the PWL-bit signed range; it shows up as the two
   // top accumulator bits disagreeing. That product is reported as 0 rather than
   // as the raw low slice, which would read back as the most negative value.
   assign wrap = acc_d[ACW-1] ^ acc_d[ACW-2];
   assign prod = wrap ? '0 : acc_d[PWL-1:0];

   // Operand capture, accumulator and bit counter.
   always_ff @(posedge clk or negedge nres) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (!nres) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         a_q   <= a;
         b_q   <= b;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + CW'(1);
         if (is_msb) run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/mul_arb_ctrl.sv
// Round-robin arbiter and sequencer that shares one iterative signed
// multiplier among NREQ requesters. The arbiter grants one requester at a
// time, runs SZin multiply steps, and then returns the product tagged with the
// owner's index.
// Optional build macro MUL_ARB_OVF_EN adds the rsp_ovf output. rsp_ovf flags
// the single unrepresentable product, (-2^(SZin-1)) * (-2^(SZin-1)).
module mul_arb_ctrl
   import mul_arb_pkg::*;
#(
   parameter int SZin = 8,
   parameter int NREQ = 4,
   parameter int IDW  = 2
)(
   input  logic                 clk,
   input  logic                 nres,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*SZin-1:0] op_a,
   input  logic [NREQ*SZin-1:0] op_b,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [2*SZin-2:0]    rsp_data
`ifdef MUL_ARB_OVF_EN
   ,
   output logic                 rsp_ovf
`endif
);

   state_e              state_q;
   state_e              state_d;
   logic                start;
   logic [IDW-1:0]      win;
   logic [IDW-1:0]      ptr_q;
   logic [IDW-1:0]      id_q;
   logic [SZin-1:0]     sel_a;
   logic [SZin-1:0]     sel_b;
   logic                core_done;
   logic [2*SZin-2:0]   core_prod;

   // The winner is computed every cycle but used only on the capture edge.
   assign win   = IDW'(rr_next(16'(req), 4'(ptr_q), NREQ));
   assign sel_a = op_a[win*SZin +: SZin];
   assign sel_b = op_b[win*SZin +: SZin];
   assign busy  = (state_q != S_IDLE);

   mul_seq_core #(.SZ(SZin)) u_core (
      .clk   (clk),
      .nres  (nres),
      .start (start),
      .a     (sel_a),
      .b     (sel_b),
      .done  (core_done),
      .prod  (core_prod)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge nres) begin
      if (!nres) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic. Requests are looked at only in IDLE, so a level held
   // through RUN/DONE counts as a fresh request once back in IDLE.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               start   = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (core_done) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Grant pulse, rotation pointer, owner id and the held response registers.
   // The pointer resets to NREQ-1 so requester 0 wins the first arbitration.
   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         ptr_q     <= IDW'(NREQ - 1);
         id_q      <= '0;
      end else begin
         gnt       <= '0;
         rsp_valid <= 1'b0;
         if (start) begin
            gnt   <= NREQ'(1) << win;
            ptr_q <= win;
            id_q  <= win;
         end
         if (core_done) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_q;
            rsp_data  <= core_prod;
         end
      end
   end

`ifdef MUL_ARB_OVF_EN
   localparam logic [SZin-1:0] MOST_NEG = {1'b1, {(SZin-1){1'b0}}};

   logic ovf_cap;

   // Overflow flag: decided from the captured operands and published with rsp_data.
   always_ff @(posedge clk or negedge nres) begin
      if (!nres) begin
         ovf_cap <= 1'b0;
         rsp_ovf <= 1'b0;
      end else begin
         if (start)     ovf_cap <= (sel_a == MOST_NEG) && (sel_b == MOST_NEG);
         if (core_done) rsp_ovf <= ovf_cap;
      end
   end
`endif

endmodule

// File: tb/tb_mul_arb_ctrl.sv
// Self-checking bench for mul_arb_ctrl (SZin=5, NREQ=4).
// A transaction-level reference model runs alongside the DUT and is compared
// with it every cycle. The model tracks when the shared multiplier is free,
// which requester the rotation picks, and the true product a*b. Fixed vectors
// and hand-written sequences cover reset, latency, signed corners and rotation.
module tb_mul_arb_ctrl;

   localparam int SZ  = 5;
   localparam int NR  = 4;
   localparam int IW  = 2;
   localparam int PWD = 2 * SZ - 1;
   localparam int NV  = 11;

   logic             clk = 1'b0;
   logic             nres;
   logic [NR-1:0]    req;
   logic [NR*SZ-1:0] op_a;
   logic [NR*SZ-1:0] op_b;
   logic [NR-1:0]    gnt;
   logic             busy;
   logic             rsp_valid;
   logic [IW-1:0]    rsp_id;
   logic [PWD-1:0]   rsp_data;
`ifdef MUL_ARB_OVF_EN
   logic             rsp_ovf;
`endif

   mul_arb_ctrl #(.SZin(SZ), .NREQ(NR), .IDW(IW)) dut (
      .clk       (clk),
      .nres      (nres),
      .req       (req),
      .op_a      (op_a),
      .op_b      (op_b),
      .gnt       (gnt),
      .busy      (busy),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
`ifdef MUL_ARB_OVF_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int             cyc = 0;
   int             last_cap;
   int             ptr;
   bit             pend;
   int             pend_id;
   logic [PWD-1:0] pend_data;
   logic [NR-1:0]  m_gnt;
   logic           m_valid;
   logic           m_busy;
   logic [IW-1:0]  m_id;
   logic [PWD-1:0] m_data;
`ifdef MUL_ARB_OVF_EN
   logic           pend_ovf;
   logic           m_ovf;
`endif

   task automatic model_reset();
      last_cap = -100;
      ptr      = NR - 1;
      pend     = 0;
      m_gnt    = '0;
      m_valid  = 1'b0;
      m_busy   = 1'b0;
      m_id     = '0;
      m_data   = '0;
`ifdef MUL_ARB_OVF_EN
      m_ovf    = 1'b0;
`endif
   endtask

   // One clock edge of the model, using the inputs present at that edge.
   task automatic model_step();
      int win;
      int a_v;
      int b_v;
      int p;
      if (!nres) begin
         model_reset();
      end else begin
         m_gnt   = '0;
         m_valid = 1'b0;
         if (pend && cyc == last_cap + SZ) begin
            m_valid = 1'b1;
            m_id    = IW'(pend_id);
            m_data  = pend_data;
`ifdef MUL_ARB_OVF_EN
            m_ovf   = pend_ovf;
`endif
            pend    = 0;
         end
         if (cyc >= last_cap + SZ + 2 && req != '0) begin
            win = -1;
            for (int j = 1; j <= NR; j++) begin
               if (win < 0 && req[IW'((ptr + j) % NR)]) win = (ptr + j) % NR;
            end
            ptr       = win;
            last_cap  = cyc;
            pend      = 1;
            pend_id   = win;
            m_gnt     = NR'(1) << win;
            a_v       = int'($signed(op_a[win*SZ +: SZ]));
            b_v       = int'($signed(op_b[win*SZ +: SZ]));
            p         = a_v * b_v;
            pend_data = (p >= (1 << (PWD - 1))) ? '0 : PWD'(p);
`ifdef MUL_ARB_OVF_EN
            pend_ovf  = (p >= (1 << (PWD - 1)));
`endif
         end
         m_busy = (cyc >= last_cap) && (cyc <= last_cap + SZ);
      end
      cyc++;
   endtask

   // Advance one clock, then compare all outputs with the model on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check("cyc_gnt",       32'(gnt),       32'(m_gnt));
      check("cyc_busy",      32'(busy),      32'(m_busy));
      check("cyc_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      check("cyc_rsp_id",    32'(rsp_id),    32'(m_id));
      check("cyc_rsp_data",  32'(rsp_data),  32'(m_data));
`ifdef MUL_ARB_OVF_EN
      check("cyc_rsp_ovf",   32'(rsp_ovf),   32'(m_ovf));
`endif
   endtask

   // Wait a bounded number of cycles for rsp_valid; lat=0 means it never came.
   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int t = 1; t <= 20 && lat == 0; t++) begin
         tick();
         if (rsp_valid) lat = t;
      end
   endtask

   function automatic int onehot_idx(input logic [NR-1:0] v);
      int r;
      r = -1;
      for (int k = NR - 1; k >= 0; k--) if (v[IW'(k)]) r = k;
      return r;
   endfunction

   typedef struct {
      logic [IW-1:0]  id;
      logic [SZ-1:0]  a;
      logic [SZ-1:0]  b;
      logic [PWD-1:0] prod;
      logic           ovf;
   } vec_t;

   vec_t vecs [NV];
   int   g_id  [4];
   int   g_cyc [4];
   int   r_id  [4];
   int   n_g;
   int   n_r;
   int   lat;
   int   seen;

   initial begin
      vecs[0]  = '{id: 2'd1, a: 5'h02, b: 5'h05, prod: 9'h00A, ovf: 1'b0};  //   2 *   5 =   10
      vecs[1]  = '{id: 2'd0, a: 5'h1D, b: 5'h05, prod: 9'h1F1, ovf: 1'b0};  //  -3 *   5 =  -15
      vecs[2]  = '{id: 2'd0, a: 5'h10, b: 5'h0F, prod: 9'h110, ovf: 1'b0};  // -16 *  15 = -240
      vecs[3]  = '{id: 2'd0, a: 5'h1F, b: 5'h1F, prod: 9'h001, ovf: 1'b0};  //  -1 *  -1 =    1
      vecs[4]  = '{id: 2'd2, a: 5'h10, b: 5'h10, prod: 9'h000, ovf: 1'b1};  // -16 * -16 wraps
      vecs[5]  = '{id: 2'd3, a: 5'h0F, b: 5'h0F, prod: 9'h0E1, ovf: 1'b0};  //  15 *  15 =  225
      vecs[6]  = '{id: 2'd3, a: 5'h10, b: 5'h01, prod: 9'h1F0, ovf: 1'b0};  // -16 *   1 =  -16
      vecs[7]  = '{id: 2'd1, a: 5'h07, b: 5'h1F, prod: 9'h1F9, ovf: 1'b0};  //   7 *  -1 =   -7
      vecs[8]  = '{id: 2'd2, a: 5'h00, b: 5'h19, prod: 9'h000, ovf: 1'b0};  //   0 *  -7 =    0
      vecs[9]  = '{id: 2'd0, a: 5'h10, b: 5'h11, prod: 9'h0F0, ovf: 1'b0};  // -16 * -15 =  240
      vecs[10] = '{id: 2'd1, a: 5'h18, b: 5'h10, prod: 9'h080, ovf: 1'b0};  //  -8 * -16 =  128

      nres = 1'b0;
      req  = '0;
      op_a = '0;
      op_b = '0;
      model_reset();
      tick();
      tick();
      nres = 1'b1;
      tick();

      // Fixed vectors: single requester, operands scrambled right after capture.
      for (int i = 0; i < NV; i++) begin
         op_a = 20'($urandom);
         op_b = 20'($urandom);
         op_a[vecs[i].id*SZ +: SZ] = vecs[i].a;
         op_b[vecs[i].id*SZ +: SZ] = vecs[i].b;
         req = NR'(1) << vecs[i].id;
         tick();
         check("tbl_gnt", 32'(gnt), 32'(NR'(1) << vecs[i].id));
         req  = '0;
         op_a = 20'($urandom);
         op_b = 20'($urandom);
         wait_rsp(lat);
         check("tbl_latency",  32'(lat),      32'(SZ));
         check("tbl_rsp_id",   32'(rsp_id),   32'(vecs[i].id));
         check("tbl_rsp_data", 32'(rsp_data), 32'(vecs[i].prod));
`ifdef MUL_ARB_OVF_EN
         check("tbl_rsp_ovf",  32'(rsp_ovf),  32'(vecs[i].ovf));
`endif
         tick();
      end

      // Asynchronous reset in the middle of a multiply.
      op_a = 20'($urandom);
      op_b = 20'($urandom);
      req  = 4'b0100;
      tick();
      req = '0;
      tick();
      tick();
      #2 nres = 1'b0;
      #1;
      check("rst_async_gnt",       32'(gnt),       32'(0));
      check("rst_async_busy",      32'(busy),      32'(0));
      check("rst_async_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_async_rsp_id",    32'(rsp_id),    32'(0));
      check("rst_async_rsp_data",  32'(rsp_data),  32'(0));
      model_reset();
      tick();
      tick();
      nres = 1'b1;
      seen = 0;
      for (int t = 0; t < 10; t++) begin
         tick();
         if (rsp_valid) seen++;
      end
      check("rst_no_stale_rsp", 32'(seen), 32'(0));

      // All four request; each drops its line after its grant.
      op_a = {5'h04, 5'h03, 5'h1E, 5'h01};
      op_b = {5'h1F, 5'h06, 5'h10, 5'h07};
      req  = 4'b1111;
      n_g  = 0;
      n_r  = 0;
      for (int i = 0; i < 4; i++) begin
         g_id[i] = -1; g_cyc[i] = -1; r_id[i] = -1;
      end
      for (int t = 0; t < 60 && n_r < 4; t++) begin
         tick();
         if (gnt != '0 && n_g < 4) begin
            g_id[n_g]  = onehot_idx(gnt);
            g_cyc[n_g] = cyc;
            n_g++;
         end
         if (rsp_valid && n_r < 4) begin
            r_id[n_r] = int'(rsp_id);
            n_r++;
         end
         req = req & ~gnt;
      end
      req = '0;
      check("rr4_grant_count", 32'(n_g), 32'(4));
      check("rr4_rsp_count",   32'(n_r), 32'(4));
      for (int i = 0; i < 4; i++) begin
         check("rr4_grant_order", 32'(g_id[i]), 32'(i));
         check("rr4_rsp_order",   32'(r_id[i]), 32'(i));
      end
      for (int i = 1; i < 4; i++) begin
         check("rr4_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'(SZ + 2));
      end
      tick();
      tick();

      // Requesters 0 and 3 hold their lines continuously.
      op_a = {5'h05, 5'h00, 5'h00, 5'h1B};
      op_b = {5'h13, 5'h00, 5'h00, 5'h09};
      req  = 4'b1001;
      n_g  = 0;
      for (int i = 0; i < 4; i++) g_id[i] = -1;
      for (int t = 0; t < 60 && n_g < 4; t++) begin
         tick();
         if (gnt != '0 && n_g < 4) begin
            g_id[n_g] = onehot_idx(gnt);
            n_g++;
         end
      end
      req = '0;
      check("fair_grant_count", 32'(n_g), 32'(4));
      for (int i = 0; i < 4; i++) begin
         check("fair_order", 32'(g_id[i]), 32'((i % 2 == 0) ? 0 : 3));
      end
      for (int t = 0; t < 10; t++) tick();

      // Random traffic, operands changing every cycle, checked by the model.
      for (int t = 0; t < 500; t++) begin
         req = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
         for (int r = 0; r < NR; r++) begin
            op_a[r*SZ +: SZ] = ($urandom_range(0, 4) == 0) ? 5'h10 : SZ'($urandom);
            op_b[r*SZ +: SZ] = ($urandom_range(0, 4) == 0) ? 5'h10 : SZ'($urandom);
         end
         tick();
      end
      req = '0;
      for (int t = 0; t < 10; t++) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mul_arb_ctrl.md
Name: mul_arb_ctrl

Overview:
Round-robin arbiter and sequencer that shares one iterative two's-complement multiplier among NREQ requesters. It captures the winning requester's operands and runs a shift-add signed multiply over SZin cycles. It then returns the (2*SZin-1)-bit product tagged with the requester index. It sits between the requester ports and the multiply datapath, replacing per-requester multipliers.

Parameters:
SZin, 8, operand width in bits (signed two's complement), >= 2
NREQ, 4, number of requesters, 2..16
IDW, 2, width of requester index, = clog2(NREQ)

Ports:
clk  in  1  clock, rising edge
nres  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level
op_a  in  NREQ*SZin  packed operand A, requester i at [i*SZin +: SZin]
op_b  in  NREQ*SZin  packed operand B, same packing
gnt  out  NREQ  one-hot grant pulse, registered
busy  out  1  high whenever state != IDLE
rsp_valid  out  1  one-cycle result strobe
rsp_id  out  IDW  index of requester owning rsp_data
rsp_data  out  2*SZin-1  signed product

Behaviour:
- Reset (nres low, asynchronous): state=IDLE, gnt=0, busy=0, rsp_valid=0, rsp_id=0, rsp_data=0, accumulator=0, bit counter=0, rr pointer=NREQ-1 (requester 0 wins first).
- Reset mid-operation aborts the in-flight multiply. No response is issued and no grant is re-issued; the requester re-requests.
- States:
  - IDLE: edge with req!=0 -> capture winner's op_a/op_b, latch winner id, gnt[winner]=1 for next cycle, pointer=winner, cnt=0, acc=0 -> RUN. req==0 -> stay.
  - RUN: one operand-B bit per edge, LSB first.
    - cnt<SZin-1: acc += b[cnt] ? (sign-extended a << cnt) : 0.
    - cnt==SZin-1: acc -= b[SZin-1] ? (sign-extended a << (SZin-1)) : 0 (sign-bit correction).
    - After the cnt==SZin-1 edge -> DONE, rsp_valid=1, rsp_data=acc[2*SZin-2:0], rsp_id=latched id.
  - DONE: next edge -> IDLE, rsp_valid=0. rsp_data/rsp_id hold until the next result.
- Latency: capture edge E0; rsp_valid high in the cycle after edge E(SZin); next capture no earlier than E(SZin+2). Throughput is one op per SZin+2 cycles under continuous load.
- gnt is a single-cycle pulse in the cycle after capture. The requester drops or changes req/operands after seeing gnt. req still high while busy is ignored; if still high back in IDLE, it is a new request.
- Operands are sampled only at the capture edge; later changes have no effect.
- Round-robin: search starts at pointer+1 modulo NREQ, ascending, wrap to 0. The first set req wins.
- Simultaneous requests are resolved entirely by rotation. No requester waits more than NREQ-1 other operations.
- Arithmetic:
  - Internal accumulator is 2*SZin bits signed.
  - Output is the low 2*SZin-1 bits. This is exact for all inputs except (-2^(SZin-1))*(-2^(SZin-1)), which wraps to 0.
- Operand zero: bit steps still run; latency is fixed and data-independent.

Optional Feature:
MUL_ARB_OVF_EN
- Defined: adds output rsp_ovf (1 bit), registered with rsp_data. It is 1 only when both captured operands equal -2^(SZin-1) (product unrepresentable); reset value 0.
- Undefined: port absent; wrap behaviour is unchanged.

Decomposition:
- Package mul_arb_pkg:
  - state encoding IDLE/RUN/DONE (2-bit)
  - localparams PW=2*SZin-1 and ACCW=2*SZin
  - rr-next-index function
- Sub-module mul_seq_core holds the iterative datapath (acc, cnt, captured a/b).
  - Inputs: start, a, b.
  - Outputs: done pulse, prod.
  - mul_arb_ctrl keeps arbitration, id tracking and the FSM.

Test Plan:
SZin=5, NREQ=4 throughout.
1. Reset: nres low mid-RUN -> all outputs 0 within the same cycle (async); no rsp_valid after release; pointer restarts at requester 0.
2. Single requester 1: a=5'b00010, b=5'b00101 -> gnt=4'b0010 one cycle; rsp_valid exactly 5 cycles after the capture edge; rsp_id=1; rsp_data=9'd10.
3. Signed cases on requester 0:
   - a=-3, b=5 -> rsp_data=9'h1F1 (-15).
   - a=-16, b=15 -> 9'h110 (-240).
   - a=-1, b=-1 -> 9'd1.
4. req=4'b1111 held, each dropping its bit after its gnt -> grant order 0,1,2,3; responses in the same order with matching rsp_id; spacing 7 cycles.
5. Fairness: req=4'b1001 held continuously -> grants alternate 0,3,0,3; requester 3 is never starved.
6. a=b=-16: rsp_data=9'd0. With MUL_ARB_OVF_EN, rsp_ovf=1; for a=-16, b=15, rsp_ovf=0.
